// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage and data memory.
//   dmem_req_valid / dmem_req_ready : request handshake
//   dmem_we, dmem_addr, dmem_wdata, dmem_wstrb : request payload (word address)
//   dmem_rsp_valid / dmem_rsp_rdata : single-cycle load response
// master = pipeline side (mem_stage), slave = memory side.
interface mem_stage_if #(
    parameter int DBITS = 32
);
    logic             dmem_req_valid;
    logic             dmem_req_ready;
    logic             dmem_we;
    logic [DBITS-3:0] dmem_addr;
    logic [DBITS-1:0] dmem_wdata;
    logic [3:0]       dmem_wstrb;
    logic             dmem_rsp_valid;
    logic [DBITS-1:0] dmem_rsp_rdata;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage in-order pipeline (between AGEX and WB).
// Accepts one instruction per cycle from AGEX; non-memory ops pass to the WB
// latch in one cycle, loads/stores go through the variable-latency dmem bus
// with one access outstanding, stalling AGEX meanwhile.
// Ports:
//   clk, reset (async, active-low)
//   agex_*      : instruction offered by AGEX
//   mem_stall   : AGEX must hold its offer (FSM not idle)
//   dmem        : data-memory bus (master side)
//   wb_*        : MEM->WB pipeline latch
//   pend_valid/pend_regno : outstanding load destination for hazard detection
//   misalign_sticky       : any misaligned access since reset
module mem_stage #(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5,
    parameter int INSTBITS  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 agex_valid,
    input  logic                 agex_is_load,
    input  logic                 agex_is_store,
    input  logic [2:0]           agex_funct3,
    input  logic [DBITS-1:0]     agex_addr,
    input  logic [DBITS-1:0]     agex_sdata,
    input  logic                 agex_wr_reg,
    input  logic [REGNOBITS-1:0] agex_wregno,
    input  logic [DBITS-1:0]     agex_regval,
    input  logic [DBITS-1:0]     agex_pc,
    input  logic [INSTBITS-1:0]  agex_inst,
    input  logic [DBITS-1:0]     agex_inst_count,
    output logic                 mem_stall,
    mem_stage_if.master          dmem,
    output logic                 wb_valid,
    output logic [INSTBITS-1:0]  wb_inst,
    output logic [DBITS-1:0]     wb_pc,
    output logic                 wb_wr_reg,
    output logic [REGNOBITS-1:0] wb_wregno,
    output logic [DBITS-1:0]     wb_regval,
    output logic [DBITS-1:0]     wb_inst_count,
    output logic                 wb_misalign,
    output logic                 pend_valid,
    output logic [REGNOBITS-1:0] pend_regno,
    output logic                 misalign_sticky
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REQ      = 2'b01,
        WAIT_RSP = 2'b10
    } state_t;

    state_t r_state;

    // Holding register for the single outstanding memory op
    logic                 r_h_is_load;
    logic                 r_h_we;
    logic [DBITS-3:0]     r_h_addr;
    logic [DBITS-1:0]     r_h_wdata;
    logic [3:0]           r_h_wstrb;
    logic [1:0]           r_h_lane;
    logic [2:0]           r_h_funct3;
    logic [REGNOBITS-1:0] r_h_wregno;
    logic [DBITS-1:0]     r_h_pc;
    logic [INSTBITS-1:0]  r_h_inst;
    logic [DBITS-1:0]     r_h_inst_count;

    logic             w_accept;
    logic             w_is_mem;
    logic             w_misalign;
    logic             w_in_req;
    logic [DBITS-1:0] w_st_wdata;
    logic [3:0]       w_st_wstrb;
    logic [DBITS-1:0] w_rsp_shift;
    logic [DBITS-1:0] w_ld_data;

    assign mem_stall = (r_state != IDLE);
    assign w_accept  = agex_valid & ~mem_stall;
    assign w_is_mem  = agex_is_load | agex_is_store;
    assign w_in_req  = (r_state == REQ);

    // Bus payload is zeroed outside REQ so it only ever shows the live request
    assign dmem.dmem_req_valid = w_in_req;
    assign dmem.dmem_we        = w_in_req & r_h_we;
    assign dmem.dmem_addr      = w_in_req ? r_h_addr  : '0;
    assign dmem.dmem_wdata     = w_in_req ? r_h_wdata : '0;
    assign dmem.dmem_wstrb     = w_in_req ? r_h_wstrb : 4'b0000;

    assign pend_valid = (r_state != IDLE) & r_h_is_load;
    assign pend_regno = pend_valid ? r_h_wregno : '0;

    // Alignment check and store lane formatting for the offered op
    always_comb begin
        w_misalign = 1'b0;
        w_st_wdata = agex_sdata;
        w_st_wstrb = 4'b1111;
        case (agex_funct3[1:0])
            2'b00: begin
                w_st_wdata = {(DBITS/8){agex_sdata[7:0]}};
                w_st_wstrb = 4'b0001 << agex_addr[1:0];
            end
            2'b01: begin
                w_misalign = w_is_mem & agex_addr[0];
                w_st_wdata = {(DBITS/16){agex_sdata[15:0]}};
                w_st_wstrb = agex_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_misalign = w_is_mem & (agex_addr[1:0] != 2'b00);
            end
            default: begin
                w_misalign = 1'b0;
            end
        endcase
        if (agex_is_load) begin
            w_st_wstrb = 4'b0000;
        end else begin
            w_st_wstrb = w_st_wstrb;
        end
    end

    // Load lane selection and sign/zero extension of the response word
    always_comb begin
        w_rsp_shift = dmem.dmem_rsp_rdata >> {r_h_lane, 3'b000};
        case (r_h_funct3)
            3'b000:  w_ld_data = {{(DBITS-8){w_rsp_shift[7]}}, w_rsp_shift[7:0]};
            3'b001:  w_ld_data = {{(DBITS-16){w_rsp_shift[15]}}, w_rsp_shift[15:0]};
            3'b100:  w_ld_data = {{(DBITS-8){1'b0}}, w_rsp_shift[7:0]};
            3'b101:  w_ld_data = {{(DBITS-16){1'b0}}, w_rsp_shift[15:0]};
            default: w_ld_data = w_rsp_shift;
        endcase
    end

    // Control FSM, holding register and MEM->WB latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_h_is_load     <= 1'b0;
            r_h_we          <= 1'b0;
            r_h_addr        <= '0;
            r_h_wdata       <= '0;
            r_h_wstrb       <= 4'b0000;
            r_h_lane        <= 2'b00;
            r_h_funct3      <= 3'b000;
            r_h_wregno      <= '0;
            r_h_pc          <= '0;
            r_h_inst        <= '0;
            r_h_inst_count  <= '0;
            wb_valid        <= 1'b0;
            wb_inst         <= '0;
            wb_pc           <= '0;
            wb_wr_reg       <= 1'b0;
            wb_wregno       <= '0;
            wb_regval       <= '0;
            wb_inst_count   <= '0;
            wb_misalign     <= 1'b0;
            misalign_sticky <= 1'b0;
        end else begin
            // Bubble unless a branch below retires something into the latch
            wb_valid      <= 1'b0;
            wb_inst       <= '0;
            wb_pc         <= '0;
            wb_wr_reg     <= 1'b0;
            wb_wregno     <= '0;
            wb_regval     <= '0;
            wb_inst_count <= '0;
            wb_misalign   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_is_mem) begin
                        wb_valid      <= 1'b1;
                        wb_inst       <= agex_inst;
                        wb_pc         <= agex_pc;
                        wb_wr_reg     <= agex_wr_reg;
                        wb_wregno     <= agex_wregno;
                        wb_regval     <= agex_regval;
                        wb_inst_count <= agex_inst_count;
                    end else if (w_accept && w_misalign) begin
                        // Retired without any bus activity and without a write
                        wb_valid        <= 1'b1;
                        wb_inst         <= agex_inst;
                        wb_pc           <= agex_pc;
                        wb_wregno       <= agex_wregno;
                        wb_inst_count   <= agex_inst_count;
                        wb_misalign     <= 1'b1;
                        misalign_sticky <= 1'b1;
                    end else if (w_accept) begin
                        r_h_is_load    <= agex_is_load;
                        r_h_we         <= agex_is_store & ~agex_is_load;
                        r_h_addr       <= agex_addr[DBITS-1:2];
                        r_h_wdata      <= agex_is_load ? '0 : w_st_wdata;
                        r_h_wstrb      <= w_st_wstrb;
                        r_h_lane       <= agex_addr[1:0];
                        r_h_funct3     <= agex_funct3;
                        r_h_wregno     <= agex_wregno;
                        r_h_pc         <= agex_pc;
                        r_h_inst       <= agex_inst;
                        r_h_inst_count <= agex_inst_count;
                        r_state        <= REQ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem.dmem_req_ready && r_h_is_load) begin
                        r_state <= WAIT_RSP;
                    end else if (dmem.dmem_req_ready) begin
                        wb_valid      <= 1'b1;
                        wb_inst       <= r_h_inst;
                        wb_pc         <= r_h_pc;
                        wb_wregno     <= r_h_wregno;
                        wb_inst_count <= r_h_inst_count;
                        r_state       <= IDLE;
                    end else begin
                        r_state <= REQ;
                    end
                end
                WAIT_RSP: begin
                    if (dmem.dmem_rsp_valid) begin
                        wb_valid      <= 1'b1;
                        wb_inst       <= r_h_inst;
                        wb_pc         <= r_h_pc;
                        wb_wr_reg     <= 1'b1;
                        wb_wregno     <= r_h_wregno;
                        wb_regval     <= w_ld_data;
                        wb_inst_count <= r_h_inst_count;
                        r_state       <= IDLE;
                    end else begin
                        r_state <= WAIT_RSP;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        agex_valid;
    logic        agex_is_load;
    logic        agex_is_store;
    logic [2:0]  agex_funct3;
    logic [31:0] agex_addr;
    logic [31:0] agex_sdata;
    logic        agex_wr_reg;
    logic [4:0]  agex_wregno;
    logic [31:0] agex_regval;
    logic [31:0] agex_pc;
    logic [31:0] agex_inst;
    logic [31:0] agex_inst_count;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic [31:0] wb_pc;
    logic        wb_wr_reg;
    logic [4:0]  wb_wregno;
    logic [31:0] wb_regval;
    logic [31:0] wb_inst_count;
    logic        wb_misalign;
    logic        pend_valid;
    logic [4:0]  pend_regno;
    logic        misalign_sticky;

    int n_checks;
    int n_errors;

    mem_stage_if #(.DBITS(32)) dmem_bus ();

    mem_stage #(.DBITS(32), .REGNOBITS(5), .INSTBITS(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .agex_valid      (agex_valid),
        .agex_is_load    (agex_is_load),
        .agex_is_store   (agex_is_store),
        .agex_funct3     (agex_funct3),
        .agex_addr       (agex_addr),
        .agex_sdata      (agex_sdata),
        .agex_wr_reg     (agex_wr_reg),
        .agex_wregno     (agex_wregno),
        .agex_regval     (agex_regval),
        .agex_pc         (agex_pc),
        .agex_inst       (agex_inst),
        .agex_inst_count (agex_inst_count),
        .mem_stall       (mem_stall),
        .dmem            (dmem_bus),
        .wb_valid        (wb_valid),
        .wb_inst         (wb_inst),
        .wb_pc           (wb_pc),
        .wb_wr_reg       (wb_wr_reg),
        .wb_wregno       (wb_wregno),
        .wb_regval       (wb_regval),
        .wb_inst_count   (wb_inst_count),
        .wb_misalign     (wb_misalign),
        .pend_valid      (pend_valid),
        .pend_regno      (pend_regno),
        .misalign_sticky (misalign_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic offer(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic wr, input logic [4:0] rno, input logic [31:0] rval,
                         input logic [31:0] pc);
        agex_valid      = 1'b1;
        agex_is_load    = ld;
        agex_is_store   = st;
        agex_funct3     = f3;
        agex_addr       = addr;
        agex_sdata      = sdata;
        agex_wr_reg     = wr;
        agex_wregno     = rno;
        agex_regval     = rval;
        agex_pc         = pc;
        agex_inst       = pc ^ 32'h0000_0013;
        agex_inst_count = pc >> 2;
    endtask

    // Advance one clock edge and settle; inputs change 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        wr;
        logic [4:0]  rno;
        logic [31:0] rval;
        logic        e_wr;
        logic [31:0] e_val;
        logic        e_mis;
        logic        e_sticky;
    } vec_t;

    vec_t vecs[7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        agex_valid = 1'b0; agex_is_load = 1'b0; agex_is_store = 1'b0;
        agex_funct3 = 3'b000; agex_addr = 32'h0; agex_sdata = 32'h0;
        agex_wr_reg = 1'b0; agex_wregno = 5'd0; agex_regval = 32'h0;
        agex_pc = 32'h0; agex_inst = 32'h0; agex_inst_count = 32'h0;
        dmem_bus.dmem_req_ready = 1'b1;
        dmem_bus.dmem_rsp_valid = 1'b0;
        dmem_bus.dmem_rsp_rdata = 32'h0;

        //            ld    st    f3      addr          wr    rno    rval           e_wr  e_val          mis   sticky
        vecs[0] = '{1'b0, 1'b0, 3'b000, 32'h0000_0000, 1'b1, 5'd5,  32'h0000_0042, 1'b1, 32'h0000_0042, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 3'b000, 32'h0000_0000, 1'b0, 5'd3,  32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 3'b000, 32'h0000_0000, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 1'b1, 5'd9,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 3'b000, 32'h0000_0000, 1'b1, 5'd6,  32'h0000_55AA, 1'b1, 32'h0000_55AA, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 3'b001, 32'h0000_0103, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 3'b101, 32'h0000_0105, 1'b1, 5'd11, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_req_valid", dmem_bus.dmem_req_valid, 0);
        chk("rst_pend", pend_valid, 0);
        chk("rst_sticky", misalign_sticky, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Single-cycle ops: non-memory pass-through and misaligned accesses
        for (int i = 0; i < 7; i++) begin
            offer(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, 32'h1111_2222,
                  vecs[i].wr, vecs[i].rno, vecs[i].rval, 32'h1000 + 32'(i) * 32'd4);
            step();
            agex_valid = 1'b0;
            chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
            chk($sformatf("v%0d_wr_reg", i), wb_wr_reg, vecs[i].e_wr);
            chk($sformatf("v%0d_wregno", i), wb_wregno, vecs[i].rno);
            chk($sformatf("v%0d_regval", i), wb_regval, vecs[i].e_val);
            chk($sformatf("v%0d_pc", i), wb_pc, 32'h1000 + 32'(i) * 32'd4);
            chk($sformatf("v%0d_misalign", i), wb_misalign, vecs[i].e_mis);
            chk($sformatf("v%0d_sticky", i), misalign_sticky, vecs[i].e_sticky);
            chk($sformatf("v%0d_no_req", i), dmem_bus.dmem_req_valid, 0);
            chk($sformatf("v%0d_stall", i), mem_stall, 0);
        end

        // SW addr 0x100 with ready high
        offer(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 32'h2000);
        step();
        agex_valid = 1'b0;
        chk("sw_req_valid", dmem_bus.dmem_req_valid, 1);
        chk("sw_addr", dmem_bus.dmem_addr, 32'h40);
        chk("sw_wstrb", dmem_bus.dmem_wstrb, 32'hF);
        chk("sw_we", dmem_bus.dmem_we, 1);
        chk("sw_wdata", dmem_bus.dmem_wdata, 32'hDEAD_BEEF);
        chk("sw_stall_c1", mem_stall, 1);
        chk("sw_bubble", wb_valid, 0);
        chk("sw_pend", pend_valid, 0);
        step();
        chk("sw_wb_valid", wb_valid, 1);
        chk("sw_wb_wr_reg", wb_wr_reg, 0);
        chk("sw_wb_pc", wb_pc, 32'h2000);
        chk("sw_stall_c2", mem_stall, 0);
        chk("sw_req_done", dmem_bus.dmem_req_valid, 0);

        // LB addr 0x103, response three cycles after handshake, ADD held behind it
        offer(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b1, 5'd7, 32'h0, 32'h3000);
        step();
        chk("lb_req_valid", dmem_bus.dmem_req_valid, 1);
        chk("lb_we", dmem_bus.dmem_we, 0);
        chk("lb_wstrb", dmem_bus.dmem_wstrb, 0);
        chk("lb_pend_req", pend_valid, 1);
        chk("lb_pend_regno_req", pend_regno, 7);
        offer(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd8, 32'h0000_0099, 32'h3004);
        step();
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("lb_wait%0d_pend", c), pend_valid, 1);
            chk($sformatf("lb_wait%0d_regno", c), pend_regno, 7);
            chk($sformatf("lb_wait%0d_stall", c), mem_stall, 1);
            chk($sformatf("lb_wait%0d_wb", c), wb_valid, 0);
            step();
        end
        dmem_bus.dmem_rsp_valid = 1'b1;
        dmem_bus.dmem_rsp_rdata = 32'h80FF_FF11;
        step();
        dmem_bus.dmem_rsp_valid = 1'b0;
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_wb_regval", wb_regval, 32'hFFFF_FF80);
        chk("lb_wb_wr_reg", wb_wr_reg, 1);
        chk("lb_wb_wregno", wb_wregno, 7);
        chk("lb_pend_clear", pend_valid, 0);
        chk("lb_stall_clear", mem_stall, 0);
        step();
        agex_valid = 1'b0;
        chk("add_after_lb_valid", wb_valid, 1);
        chk("add_after_lb_regval", wb_regval, 32'h0000_0099);
        chk("add_after_lb_regno", wb_wregno, 8);
        chk("sticky_persist", misalign_sticky, 1);

        // LHU addr 0x102, response the cycle after handshake
        offer(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 1'b1, 5'd4, 32'h0, 32'h4000);
        step();
        agex_valid = 1'b0;
        chk("lhu_addr", dmem_bus.dmem_addr, 32'h40);
        step();
        dmem_bus.dmem_rsp_valid = 1'b1;
        dmem_bus.dmem_rsp_rdata = 32'h8001_1234;
        step();
        dmem_bus.dmem_rsp_valid = 1'b0;
        chk("lhu_wb_regval", wb_regval, 32'h0000_8001);
        chk("lhu_wb_wregno", wb_wregno, 4);

        // SH addr 0x102 with one cycle of back-pressure
        dmem_bus.dmem_req_ready = 1'b0;
        offer(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 1'b0, 5'd0, 32'h0, 32'h5000);
        step();
        agex_valid = 1'b0;
        step();
        chk("sh_hold_valid", dmem_bus.dmem_req_valid, 1);
        chk("sh_wdata", dmem_bus.dmem_wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", dmem_bus.dmem_wstrb, 32'hC);
        chk("sh_hold_wb", wb_valid, 0);
        dmem_bus.dmem_req_ready = 1'b1;
        step();
        chk("sh_wb_valid", wb_valid, 1);
        chk("sh_stall", mem_stall, 0);

        // Reset while waiting for a load response; a later stray pulse is ignored
        offer(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b1, 5'd12, 32'h0, 32'h6000);
        step();
        agex_valid = 1'b0;
        step();
        chk("rw_pend_before", pend_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rw_stall", mem_stall, 0);
        chk("rw_req_valid", dmem_bus.dmem_req_valid, 0);
        chk("rw_pend", pend_valid, 0);
        chk("rw_pend_regno", pend_regno, 0);
        chk("rw_sticky", misalign_sticky, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        dmem_bus.dmem_rsp_valid = 1'b1;
        dmem_bus.dmem_rsp_rdata = 32'hFFFF_FFFF;
        step();
        dmem_bus.dmem_rsp_valid = 1'b0;
        chk("stray_wb_valid", wb_valid, 0);
        chk("stray_wb_regval", wb_regval, 0);
        chk("stray_stall", mem_stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the 5-stage in-order pipeline, between AGEX and WB. Accepts one instruction per cycle from AGEX and performs loads and stores through a variable-latency data-memory request/response handshake. It stalls AGEX while an access is outstanding and registers the result into the latch consumed by WB. It also exposes the pending load destination so DE can detect hazards.

Parameters:
DBITS, 32, data/address width
REGNOBITS, 5, register index width
INSTBITS, 32, instruction width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
agex_valid  in  1  AGEX offers an instruction
agex_is_load  in  1  load op
agex_is_store  in  1  store op
agex_funct3  in  3  RV32 size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
agex_addr  in  DBITS  effective address
agex_sdata  in  DBITS  store data
agex_wr_reg  in  1  writes a register
agex_wregno  in  REGNOBITS  destination register
agex_regval  in  DBITS  ALU result (non-memory ops)
agex_pc  in  DBITS  PC
agex_inst  in  INSTBITS  instruction
agex_inst_count  in  DBITS  retired-instruction tag
mem_stall  out  1  AGEX must hold its offer
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_we  out  1  1 = store
dmem_addr  out  DBITS-2  word address (addr[DBITS-1:2])
dmem_wdata  out  DBITS  lane-aligned store data
dmem_wstrb  out  4  byte enables
dmem_rsp_valid  in  1  load data valid (single-cycle pulse)
dmem_rsp_rdata  in  DBITS  load word
wb_valid, wb_inst, wb_pc, wb_wr_reg, wb_wregno, wb_regval, wb_inst_count  out  1/INSTBITS/DBITS/1/REGNOBITS/DBITS/DBITS  MEM latch to WB
wb_misalign  out  1  latched instruction was misaligned
pend_valid  out  1  load outstanding
pend_regno  out  REGNOBITS  its destination
misalign_sticky  out  1  any misalignment since reset

Behaviour:
- FSM states: IDLE, REQ, WAIT_RSP. Reset (reset=0, async) forces IDLE and zeroes all registered outputs and the holding register. dmem_req_valid, mem_stall and pend_valid drop in the same cycle reset asserts.
- mem_stall = (state != IDLE), combinational. An instruction is accepted when agex_valid && !mem_stall.
- Non-memory accept: fields are registered into the WB latch at the next edge; wb_valid=1. Latency is 1 cycle.
- Memory accept (aligned): fields are captured into the holding register; state goes to REQ; WB latch gets a bubble (wb_valid=0, all other wb_* fields 0).
- REQ: dmem_req_valid=1 with stable addr/we/wdata/wstrb until dmem_req_ready. On handshake, a store goes to IDLE and writes the WB latch (wr_reg=0, wb_valid=1). A load goes to WAIT_RSP.
- WAIT_RSP: wait for dmem_rsp_valid. On the response, select the lane by addr[1:0], sign- or zero-extend per funct3, write the WB latch with wr_reg=1 and regval = extended data, then go to IDLE. A response on the handshake cycle itself is not permitted; the response arrives no earlier than the next cycle.
- dmem_rsp_valid in IDLE or REQ is ignored. This covers stale responses after reset.
- Store formatting: SB replicates the byte to all lanes with wstrb = 1<<addr[1:0]. SH replicates the halfword with wstrb = 0011 or 1100. SW uses 1111. Loads use we=0 and wstrb=0000.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0. No dmem request is issued and the FSM stays in IDLE. The WB latch gets wb_valid=1, wr_reg=0, wb_misalign=1 one cycle later. misalign_sticky is set and stays set until reset.
- pend_valid=1 / pend_regno = held wregno while the held op is a load in REQ or WAIT_RSP; otherwise pend_valid=0 and pend_regno=0.
- Throughput: one memory op is outstanding at a time. A back-to-back memory op is accepted in the cycle the FSM is in IDLE.
- agex_wr_reg=1 with wregno=0 is passed through unchanged; DE/WB discards writes to x0.

Test Plan:
- ADD result 0x0000_0042, wregno 5, ready=1 -> next cycle wb_valid=1, wb_regval=0x42, wb_wregno=5, no dmem_req_valid.
- SW addr 0x100, data 0xDEADBEEF, ready=1 -> cycle1 req_valid, dmem_addr=0x40, wstrb=1111; cycle2 wb_valid=1, wb_wr_reg=0; mem_stall high in cycle1 only.
- LB addr 0x103, rsp 0x80FF_FF11 arriving 3 cycles after handshake -> wb_regval=0xFFFF_FF80, wb_wr_reg=1; pend_valid=1 with pend_regno correct throughout the wait; a following ADD is held by mem_stall and appears in the WB latch one cycle after the load.
- LHU addr 0x102, rsp 0x8001_1234 -> 0x0000_8001. SH addr 0x102, data 0x0000_ABCD -> wdata 0xABCD_ABCD, wstrb 1100.
- LW addr 0x101 -> no request; wb_misalign=1, wb_wr_reg=0, misalign_sticky=1 persisting through later ops.
- Reset asserted in WAIT_RSP, then a rsp_valid pulse after release -> all outputs 0, state IDLE, pulse ignored (wb_valid stays 0).
